fpcvt: RTL and testbench

Registered converter from a 13-bit two's-complement integer to an 9-bit sign/exponent/mantissa floating-point code (S, E, F). The value represented is (−1)^S × F × 2^E. The block sits on a data path between an integer source and a compact floating-point consumer. It samples its input every clock and presents the converted code one cycle later.

---
 rtl/fpcvt_if.sv | 11 +
 rtl/fpcvt.sv | 111 +++++++++++
 tb/tb_fpcvt.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpcvt_if.sv
// Integer-in / float-code-out bundle for fpcvt.
// The master drives D and receives the registered S/E/F code.
interface fpcvt_if;
    logic [12:0] D;
    logic        S;
    logic [2:0]  E;
    logic [4:0]  F;

    modport master (output D, input S, E, F);
    modport slave  (input D, output S, E, F);
endinterface

// File: rtl/fpcvt.sv
// Converts a 13-bit two's-complement integer into a registered (S, E, F) code,
// where value = (-1)^S * F * 2^E, with round-half-up on the bit below F.
module fpcvt (
    input  logic     clk,
    input  logic     rst,
    fpcvt_if.slave   cvt
);

    localparam int DATA_W = 13;
    localparam int MAG_W  = DATA_W - 1;

    function automatic logic [3:0] lead_zeros(input logic [MAG_W-1:0] m);
        logic [3:0] n;
        logic       found;
        n     = 4'd12;
        found = 1'b0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            if (!found && m[i]) begin
                n     = 4'(MAG_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // F = 31 with a round bit carries into the exponent, or clamps at E = 7.
    function automatic logic [7:0] round_half_up(input logic [2:0] e,
                                                 input logic [4:0] f,
                                                 input logic       r);
        logic [7:0] res;
        if (!r) begin
            res = {e, f};
        end else if (f != 5'h1f) begin
            res = {e, 5'(f + 5'd1)};
        end else if (e != 3'd7) begin
            res = {3'(e + 3'd1), 5'b10000};
        end else begin
            res = {3'd7, 5'h1f};
        end
        return res;
    endfunction

    function automatic logic [7:0] saturate_code();
        return {3'd7, 5'h1f};
    endfunction

    logic signed [DATA_W-1:0] d_s;
    logic                     sign_d;
    logic                     sat_d;
    logic [MAG_W-1:0]         mag_d;
    logic [3:0]               lz_d;
    logic [MAG_W-1:0]         norm_d;
    logic [2:0]               e_trunc_d;
    logic [4:0]               f_trunc_d;
    logic                     r_d;
    logic [7:0]               code_d;
    logic                     s_d;
    logic [2:0]               e_d;
    logic [4:0]               f_d;

    logic                     s_q;
    logic [2:0]               e_q;
    logic [4:0]               f_q;

    assign d_s    = signed'(cvt.D);
    assign sign_d = d_s[DATA_W-1];
    // -4096 is the only input whose low 12 bits are zero while negative.
    assign sat_d  = sign_d && (cvt.D[MAG_W-1:0] == '0);
    assign mag_d  = sign_d ? MAG_W'(~cvt.D[MAG_W-1:0] + 12'd1) : cvt.D[MAG_W-1:0];
    assign lz_d   = lead_zeros(mag_d);
    assign norm_d = mag_d << lz_d;

    always_comb begin
        e_trunc_d = 3'd0;
        f_trunc_d = mag_d[4:0];
        r_d       = 1'b0;
        if (lz_d <= 4'd6) begin
            e_trunc_d = 3'(4'd7 - lz_d);
            f_trunc_d = norm_d[11:7];
            r_d       = norm_d[6];
        end
    end

    always_comb begin
        code_d = round_half_up(e_trunc_d, f_trunc_d, r_d);
        if (sat_d) begin
            code_d = saturate_code();
        end
        s_d = sign_d;
        e_d = code_d[7:5];
        f_d = code_d[4:0];
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= 1'b0;
            e_q <= 3'd0;
            f_q <= 5'd0;
        end else begin
            s_q <= s_d;
            e_q <= e_d;
            f_q <= f_d;
        end
    end

    assign cvt.S = s_q;
    assign cvt.E = e_q;
    assign cvt.F = f_q;

endmodule

// File: tb/tb_fpcvt.sv
// Self-checking bench for fpcvt: directed vectors, random streams against an
// arithmetic reference model, and asynchronous reset behaviour.
module tb_fpcvt;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fpcvt_if bus();

    fpcvt dut (
        .clk (clk),
        .rst (rst),
        .cvt (bus)
    );

    always #5 clk = ~clk;

    // Reference: find the scale that brings |D| into 0..31, then round on the
    // next lower bit with plain integer arithmetic.
    function automatic logic [8:0] ref_model(input logic [12:0] d);
        int v, m, e, f, r;
        logic s;
        v = int'(signed'(d));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 4096) return {1'b1, 3'd7, 5'd31};
        e = 0;
        while ((m >> e) > 31) e++;
        f = m >> e;
        r = (e > 0) ? ((m >> (e - 1)) & 1) : 0;
        f = f + r;
        if (f == 32) begin
            if (e < 7) begin
                f = 16;
                e = e + 1;
            end else begin
                f = 31;
            end
        end
        return {s, 3'(e), 5'(f)};
    endfunction

    function automatic logic [8:0] outs();
        return {bus.S, bus.E, bus.F};
    endfunction

    task automatic test_reset();
        logic [8:0] got;
        rst   = 1'b1;
        bus.D = 13'b0_1101_0010_0000;
        repeat (3) begin
            @(posedge clk);
            #1;
            got = outs();
            total++;
            if (got !== 9'd0) begin
                bad++;
                $display("FAIL reset_hold got S=%0d E=%0d F=%b want S=0 E=0 F=00000",
                         got[8], got[7:5], got[4:0]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        got = outs();
        total++;
        if (got !== {1'b0, 3'd7, 5'b11010}) begin
            bad++;
            $display("FAIL reset_release got S=%0d E=%0d F=%b want S=0 E=7 F=11010",
                     got[8], got[7:5], got[4:0]);
        end
    endtask

    task automatic test_directed();
        logic [12:0] dv [15];
        logic [8:0]  ev [15];
        logic [8:0]  got;
        dv[0]  = 13'b0_0101_0100_0000; ev[0]  = {1'b0, 3'd6, 5'b10101};
        dv[1]  = 13'b0_0000_1010_0000; ev[1]  = {1'b0, 3'd3, 5'b10100};
        dv[2]  = 13'b0_0000_0000_0001; ev[2]  = {1'b0, 3'd0, 5'b00001};
        dv[3]  = 13'b1_1111_1111_1110; ev[3]  = {1'b1, 3'd0, 5'b00010};
        dv[4]  = 13'b0_1101_0110_0000; ev[4]  = {1'b0, 3'd7, 5'b11011};
        dv[5]  = 13'b0_0000_1010_0100; ev[5]  = {1'b0, 3'd3, 5'b10101};
        dv[6]  = 13'b1_1010_1010_0000; ev[6]  = {1'b1, 3'd6, 5'b10110};
        dv[7]  = 13'b1_1111_0101_1100; ev[7]  = {1'b1, 3'd3, 5'b10101};
        dv[8]  = 13'b0_0111_1110_0000; ev[8]  = {1'b0, 3'd7, 5'b10000};
        dv[9]  = 13'b0_0000_1111_1100; ev[9]  = {1'b0, 3'd4, 5'b10000};
        dv[10] = 13'b1_1100_0000_1100; ev[10] = {1'b1, 3'd6, 5'b10000};
        dv[11] = 13'b1_1111_0000_0100; ev[11] = {1'b1, 3'd4, 5'b10000};
        dv[12] = 13'b0_1111_1111_1111; ev[12] = {1'b0, 3'd7, 5'b11111};
        dv[13] = 13'b1_0000_0000_0000; ev[13] = {1'b1, 3'd7, 5'b11111};
        dv[14] = 13'b0_0000_0000_0000; ev[14] = {1'b0, 3'd0, 5'b00000};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.D = dv[i];
            @(posedge clk);
            #1;
            got = outs();
            total++;
            if (got !== ev[i]) begin
                bad++;
                $display("FAIL directed[%0d] d=%b got S=%0d E=%0d F=%b want S=%0d E=%0d F=%b",
                         i, dv[i], got[8], got[7:5], got[4:0], ev[i][8], ev[i][7:5], ev[i][4:0]);
            end
        end
    endtask

    task automatic test_corners();
        int          vals [14];
        logic [12:0] d;
        logic [8:0]  got, exp;
        vals = '{-4096, -4095, 4095, 31, 32, 63, 64, -32, -33, 2047, 2048, -2048, 1008, -1};
        for (int i = 0; i < 14; i++) begin
            d = 13'(vals[i]);
            exp = ref_model(d);
            @(negedge clk);
            bus.D = d;
            @(posedge clk);
            #1;
            got = outs();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL corner d=%0d got S=%0d E=%0d F=%b want S=%0d E=%0d F=%b",
                         vals[i], got[8], got[7:5], got[4:0], exp[8], exp[7:5], exp[4:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  expq [$];
        logic [12:0] dq [$];
        logic [8:0]  got, exp;
        logic [12:0] d, dprev;
        @(negedge clk);
        d = 13'($urandom);
        bus.D = d;
        expq.push_back(ref_model(d));
        dq.push_back(d);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            got   = outs();
            exp   = expq.pop_front();
            dprev = dq.pop_front();
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL stream d=%b got S=%0d E=%0d F=%b want S=%0d E=%0d F=%b",
                         dprev, got[8], got[7:5], got[4:0], exp[8], exp[7:5], exp[4:0]);
            end
            // Bias some cycles toward small magnitudes so low exponents are exercised.
            d = (i % 3 == 0) ? 13'($urandom_range(0, 127)) : 13'($urandom);
            if (i % 7 == 0) d = -d;
            bus.D = d;
            expq.push_back(ref_model(d));
            dq.push_back(d);
        end
        @(negedge clk);
        got   = outs();
        exp   = expq.pop_front();
        dprev = dq.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL stream_last d=%b got S=%0d E=%0d F=%b want S=%0d E=%0d F=%b",
                     dprev, got[8], got[7:5], got[4:0], exp[8], exp[7:5], exp[4:0]);
        end
    endtask

    task automatic test_async_reset();
        logic [8:0]  got, exp;
        logic [12:0] d;
        @(negedge clk);
        bus.D = 13'b0_1101_0010_0000;
        @(posedge clk);
        #1;
        got = outs();
        total++;
        if (got !== {1'b0, 3'd7, 5'b11010}) begin
            bad++;
            $display("FAIL async_pre got S=%0d E=%0d F=%b want S=0 E=7 F=11010",
                     got[8], got[7:5], got[4:0]);
        end
        #2;
        rst = 1'b1;
        #1;
        got = outs();
        total++;
        if (got !== 9'd0) begin
            bad++;
            $display("FAIL async_clear got S=%0d E=%0d F=%b want S=0 E=0 F=00000",
                     got[8], got[7:5], got[4:0]);
        end
        @(posedge clk);
        #1;
        got = outs();
        total++;
        if (got !== 9'd0) begin
            bad++;
            $display("FAIL async_hold got S=%0d E=%0d F=%b want S=0 E=0 F=00000",
                     got[8], got[7:5], got[4:0]);
        end
        @(negedge clk);
        d     = 13'b1_1010_1010_0000;
        bus.D = d;
        rst   = 1'b0;
        exp   = ref_model(d);
        @(posedge clk);
        #1;
        got = outs();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL async_resume got S=%0d E=%0d F=%b want S=%0d E=%0d F=%b",
                     got[8], got[7:5], got[4:0], exp[8], exp[7:5], exp[4:0]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        bus.D = '0;
        test_reset();
        test_directed();
        test_corners();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
